uart_alu_ctrl: RTL and testbench

Sequencer between the UART (RX/TX pair sharing one baud generator) and the ALU.
- Collects three bytes from the RX side: operand A, operand B, opcode.
- Drives them to the ALU as registered operands.
- Captures the ALU result and sends it back through TX with a one-cycle start pulse, then waits for TX completion.
- An inter-byte timeout discards a partial frame so a lost byte cannot desynchronise the frame.

---
 rtl/uart_alu_ctrl.sv | 116 +++++++++++
 tb/tb_uart_alu_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_ctrl.sv
// Frame sequencer between a UART RX/TX pair and a combinational ALU.
// Collects operand A, operand B and opcode bytes, then returns the ALU result through TX.
`timescale 1ns/1ps
module uart_alu_ctrl #(
    parameter int NBIT_DATA      = 8,
    parameter int NBIT_OP        = 6,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 rx_done_tick,
    input  logic [NBIT_DATA-1:0] rx_data,
    input  logic                 tx_done_tick,
    input  logic [NBIT_DATA-1:0] alu_result,
    output logic [NBIT_DATA-1:0] alu_a,
    output logic [NBIT_DATA-1:0] alu_b,
    output logic [NBIT_OP-1:0]   alu_op,
    output logic [NBIT_DATA-1:0] tx_data,
    output logic                 tx_start,
    output logic                 busy,
    output logic                 timeout,
    output logic [2:0]           dbg_state
);

    // Handshake: rx_done_tick/tx_done_tick are single-cycle strobes with no back-pressure;
    // a strobe is consumed only in the state that waits for it and silently dropped elsewhere.
    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        SEND    = 3'd3,
        WAIT_TX = 3'd4
    } state_t;

    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam int CNT_W      = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [NBIT_DATA-1:0] alu_a_n, alu_b_n, tx_data_n;
    logic [NBIT_OP-1:0]   alu_op_n;
    logic                 tx_start_n, timeout_n;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state    <= WAIT_A;
            cnt      <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            alu_a    <= alu_a_n;
            alu_b    <= alu_b_n;
            alu_op   <= alu_op_n;
            tx_data  <= tx_data_n;
            tx_start <= tx_start_n;
            timeout  <= timeout_n;
        end
    end

    // A byte arriving on the expiry cycle wins over the timeout.
    always_comb begin
        state_n    = state;
        cnt_n      = '0;
        alu_a_n    = alu_a;
        alu_b_n    = alu_b;
        alu_op_n   = alu_op;
        tx_data_n  = tx_data;
        tx_start_n = 1'b0;
        timeout_n  = 1'b0;
        case (state)
            WAIT_A: begin
                if (rx_done_tick) begin
                    alu_a_n = rx_data;
                    state_n = WAIT_B;
                end
            end
            WAIT_B, WAIT_OP: begin
                if (rx_done_tick) begin
                    if (state == WAIT_B) begin
                        alu_b_n = rx_data;
                        state_n = WAIT_OP;
                    end else begin
                        alu_op_n = rx_data[NBIT_OP-1:0];
                        state_n  = SEND;
                    end
                end else if (TIMEOUT_EN && cnt == CNT_MAX) begin
                    state_n   = WAIT_A;
                    timeout_n = 1'b1;
                end else if (TIMEOUT_EN) begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            SEND: begin
                // One settling cycle so alu_result reflects the freshly registered opcode.
                tx_data_n  = alu_result;
                tx_start_n = 1'b1;
                state_n    = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done_tick) state_n = WAIT_A;
            end
            default: state_n = WAIT_A;
        endcase
    end

    assign busy      = (state != WAIT_A);
    assign dbg_state = state;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed bench for uart_alu_ctrl: normal frames, timeout, expiry tie, dropped bytes, async reset.
`timescale 1ns/1ps
module tb_uart_alu_ctrl;

  localparam int NBIT_DATA = 8;
  localparam int NBIT_OP   = 6;
  localparam logic [2:0] S_WAIT_A  = 3'd0;
  localparam logic [2:0] S_WAIT_B  = 3'd1;
  localparam logic [2:0] S_WAIT_OP = 3'd2;
  localparam logic [2:0] S_SEND    = 3'd3;
  localparam logic [2:0] S_WAIT_TX = 3'd4;

  logic                 CLK = 1'b0;
  logic                 reset = 1'b0;
  logic                 rx_done_tick = 1'b0;
  logic [NBIT_DATA-1:0] rx_data = '0;
  logic                 tx_done_tick = 1'b0;
  logic [NBIT_DATA-1:0] alu_result;
  logic [NBIT_DATA-1:0] alu_a, alu_b, tx_data;
  logic [NBIT_OP-1:0]   alu_op;
  logic                 tx_start, busy, timeout;
  logic [2:0]           dbg_state;

  int checks = 0;
  int failures = 0;
  logic [NBIT_DATA-1:0] exp_q[$];

  // clock / reset block
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    failures++;
    $fatal(1, "watchdog expired");
  end

  // Small ALU model: 0x20 add, 0x22 subtract, anything else AND.
  assign alu_result = (alu_op == 6'h20) ? alu_a + alu_b :
                      (alu_op == 6'h22) ? alu_a - alu_b : alu_a & alu_b;

  uart_alu_ctrl #(
    .NBIT_DATA(NBIT_DATA), .NBIT_OP(NBIT_OP), .TIMEOUT_CYCLES(20)
  ) dut (
    .CLK(CLK), .reset(reset),
    .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .tx_done_tick(tx_done_tick), .alu_result(alu_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .tx_data(tx_data), .tx_start(tx_start),
    .busy(busy), .timeout(timeout), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: called at a negedge, return at a later negedge
  task automatic rx_byte(input logic [7:0] b);
    rx_data = b;
    rx_done_tick = 1'b1;
    @(negedge CLK);
    rx_done_tick = 1'b0;
  endtask

  task automatic tx_done_pulse();
    tx_done_tick = 1'b1;
    @(negedge CLK);
    tx_done_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // From SEND: check the start pulse and scoreboard byte, then release with tx_done.
  task automatic finish_tx(input string tag);
    logic [7:0] exp;
    check({tag, "_send_state"}, dbg_state, S_SEND);
    check({tag, "_start_low_in_send"}, tx_start, 1'b0);
    @(negedge CLK);
    check({tag, "_start_pulse"}, tx_start, 1'b1);
    check({tag, "_q_nonempty"}, exp_q.size() > 0, 1'b1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check({tag, "_tx_data"}, tx_data, exp);
    @(negedge CLK);
    check({tag, "_start_single"}, tx_start, 1'b0);
    check({tag, "_busy_in_tx"}, busy, 1'b1);
    tx_done_pulse();
    check({tag, "_idle_state"}, dbg_state, S_WAIT_A);
    check({tag, "_busy_clear"}, busy, 1'b0);
    check({tag, "_tx_data_hold"}, tx_data, exp);
  endtask

  initial begin
    // reset held low with rx_done_tick toggling
    for (int i = 0; i < 3; i++) begin
      rx_data = 8'hA5;
      rx_done_tick = ~rx_done_tick;
      @(negedge CLK);
    end
    check("rst_alu_a", alu_a, 8'h00);
    check("rst_alu_b", alu_b, 8'h00);
    check("rst_alu_op", alu_op, 6'h00);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", dbg_state, S_WAIT_A);
    rx_done_tick = 1'b0;
    reset = 1'b1;
    @(negedge CLK);

    // stray tx_done outside WAIT_TX is ignored
    tx_done_pulse();
    check("stray_txdone_state", dbg_state, S_WAIT_A);

    // normal frame 05 + 03
    exp_q.push_back(8'h08);
    rx_byte(8'h05);
    check("f1_alu_a", alu_a, 8'h05);
    check("f1_state_b", dbg_state, S_WAIT_B);
    check("f1_busy", busy, 1'b1);
    rx_byte(8'h03);
    check("f1_alu_b", alu_b, 8'h03);
    check("f1_state_op", dbg_state, S_WAIT_OP);
    rx_byte(8'h20);
    check("f1_alu_op", alu_op, 6'h20);
    // byte during WAIT_TX is dropped
    check("f1_send_state", dbg_state, S_SEND);
    @(negedge CLK);
    check("f1_start_pulse", tx_start, 1'b1);
    check("f1_tx_data", tx_data, exp_q.pop_front());
    rx_byte(8'h77);
    check("drop_start_low", tx_start, 1'b0);
    check("drop_alu_a", alu_a, 8'h05);
    check("drop_alu_b", alu_b, 8'h03);
    check("drop_alu_op", alu_op, 6'h20);
    check("drop_state", dbg_state, S_WAIT_TX);
    check("drop_busy", busy, 1'b1);
    tx_done_pulse();
    check("f1_done_state", dbg_state, S_WAIT_A);
    check("f1_done_busy", busy, 1'b0);

    // next frame starts with operand A; opcode byte upper bits ignored (E0 -> 20)
    exp_q.push_back(8'h03);
    rx_byte(8'h01);
    check("f2_alu_a", alu_a, 8'h01);
    rx_byte(8'h02);
    rx_byte(8'hE0);
    check("f2_alu_op", alu_op, 6'h20);
    finish_tx("f2");

    // timeout after 20 idle cycles in WAIT_B
    rx_byte(8'h11);
    check("to_alu_a", alu_a, 8'h11);
    idle(19);
    check("to_not_yet", timeout, 1'b0);
    check("to_still_b", dbg_state, S_WAIT_B);
    idle(1);
    check("to_pulse", timeout, 1'b1);
    check("to_state_a", dbg_state, S_WAIT_A);
    check("to_alu_a_stale", alu_a, 8'h11);
    idle(1);
    check("to_pulse_single", timeout, 1'b0);
    exp_q.push_back(8'h55);
    rx_byte(8'h22);
    check("to_next_alu_a", alu_a, 8'h22);
    rx_byte(8'h33);
    rx_byte(8'h20);
    finish_tx("f3");

    // byte arriving exactly on the expiry cycle is accepted
    exp_q.push_back(8'h99);
    rx_byte(8'h44);
    idle(19);
    check("tie_pre_state", dbg_state, S_WAIT_B);
    rx_byte(8'h55);
    check("tie_alu_b", alu_b, 8'h55);
    check("tie_no_timeout", timeout, 1'b0);
    check("tie_state_op", dbg_state, S_WAIT_OP);
    idle(1);
    check("tie_no_timeout_late", timeout, 1'b0);
    rx_byte(8'h20);
    finish_tx("f4");

    // async reset while in WAIT_OP, between clock edges
    rx_byte(8'hA1);
    rx_byte(8'hB2);
    check("ar_pre_state", dbg_state, S_WAIT_OP);
    #2;
    reset = 1'b0;
    #1;
    check("ar_alu_a", alu_a, 8'h00);
    check("ar_alu_b", alu_b, 8'h00);
    check("ar_tx_data", tx_data, 8'h00);
    check("ar_state", dbg_state, S_WAIT_A);
    check("ar_busy", busy, 1'b0);
    @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    exp_q.push_back(8'hFF);
    rx_byte(8'h06);
    check("ar_next_alu_a", alu_a, 8'h06);
    rx_byte(8'h07);
    rx_byte(8'h22);
    check("ar_next_alu_op", alu_op, 6'h22);
    finish_tx("f5");

    check("q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
